// File: rtl/pipeline_ctrl_if.sv
// Hazard-control bus between the pipeline datapath and pipeline_ctrl.
// The master side (datapath) presents ID/EX hazard info and the slave side
// (controller) returns stage enables, flushes and status.
interface pipeline_ctrl_if;
    logic [3:0]  id_rs1;
    logic [3:0]  id_rs2;
    logic [3:0]  id_rs3;
    logic [2:0]  id_src_use;
    logic [2:0]  id_src_vec;
    logic [3:0]  ex_rd;
    logic        ex_memtoreg;
    logic        ex_regswrite;
    logic        ex_regvwrite;
    logic        ex_vectorop;
    logic        branch_taken;
    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic [1:0]  state;
    logic [15:0] stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_rs3, id_src_use, id_src_vec, ex_rd,
               ex_memtoreg, ex_regswrite, ex_regvwrite, ex_vectorop, branch_taken,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
               state, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs3, id_src_use, id_src_vec, ex_rd,
               ex_memtoreg, ex_regswrite, ex_regvwrite, ex_vectorop, branch_taken,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
               state, stall_cycles
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use stalls, multi-cycle vector freeze,
// branch flush, plus a saturating counter of cycles with the PC held.
// Enables/flushes are decoded combinationally from the registered state and
// the current ID/EX inputs so they act in the same cycle as the hazard.
module pipeline_ctrl #(
    parameter int VEC_CYCLES = 6
) (
    input logic           clk,
    input logic           rst,
    pipeline_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        VEC_BUSY   = 2'b10,
        FLUSH      = 2'b11
    } state_t;

    // A one-cycle vector op never needs to freeze anything.
    localparam bit         VEC_EN   = (VEC_CYCLES > 1);
    // The RUN cycle that accepts the op is itself frozen, so the busy
    // countdown starts two below the total occupancy.
    localparam logic [3:0] CNT_INIT = VEC_EN ? 4'(VEC_CYCLES - 2) : 4'd0;

    state_t      state_q;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic [15:0] stall_cnt;
    logic [2:0]  src_hit;
    logic        load_hit;
    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;
    logic        if_id_flush;
    logic        id_ex_flush;

    // Per-source match against the EX load destination in the selected file.
    always_comb begin
        src_hit[0] = bus.id_src_use[0] && (bus.ex_rd == bus.id_rs1) &&
                     (bus.id_src_vec[0] ? bus.ex_regvwrite : bus.ex_regswrite);
        src_hit[1] = bus.id_src_use[1] && (bus.ex_rd == bus.id_rs2) &&
                     (bus.id_src_vec[1] ? bus.ex_regvwrite : bus.ex_regswrite);
        src_hit[2] = bus.id_src_use[2] && (bus.ex_rd == bus.id_rs3) &&
                     (bus.id_src_vec[2] ? bus.ex_regvwrite : bus.ex_regswrite);
        load_hit   = bus.ex_memtoreg && (|src_hit);
    end

    // Next-state and same-cycle enable/flush decode.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        state_nxt   = state_q;
        cnt_nxt     = cnt;
        if (rst) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            ex_mem_en   = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_nxt   = RUN;
            cnt_nxt     = 4'd0;
        end else begin
            case (state_q)
                RUN, LOAD_STALL: begin
                    state_nxt = RUN;
                    if (bus.branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        state_nxt   = FLUSH;
                    end else if (bus.ex_vectorop && VEC_EN) begin
                        pc_en     = 1'b0;
                        if_id_en  = 1'b0;
                        id_ex_en  = 1'b0;
                        ex_mem_en = 1'b0;
                        cnt_nxt   = CNT_INIT;
                        state_nxt = VEC_BUSY;
                    end else if (load_hit && (state_q == RUN)) begin
                        // The stalled consumer is re-presented next cycle
                        // when the load data is forwardable; don't re-stall.
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                        state_nxt   = LOAD_STALL;
                    end
                end
                VEC_BUSY: begin
                    if (cnt != 4'd0) begin
                        pc_en     = 1'b0;
                        if_id_en  = 1'b0;
                        id_ex_en  = 1'b0;
                        ex_mem_en = 1'b0;
                        cnt_nxt   = cnt - 4'd1;
                    end else if (load_hit) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                        state_nxt   = LOAD_STALL;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                FLUSH: begin
                    if_id_flush = 1'b1;
                    state_nxt   = RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // State, vector countdown and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            cnt       <= 4'd0;
            stall_cnt <= 16'd0;
        end else begin
            state_q <= state_nxt;
            cnt     <= cnt_nxt;
            if (!pc_en && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign bus.pc_en        = pc_en;
    assign bus.if_id_en     = if_id_en;
    assign bus.id_ex_en     = id_ex_en;
    assign bus.ex_mem_en    = ex_mem_en;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_flush  = id_ex_flush;
    assign bus.state        = rst ? RUN : state_q;
    assign bus.stall_cycles = stall_cnt;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed hazard scenarios then random traffic,
// checked each cycle against a behavioural model; a second instance with a
// 16-cycle vector op held active exercises stall counter saturation.
module tb_pipeline_ctrl;
    localparam int VC = 6;

    logic clk = 1'b0;
    logic rst;
    logic srst;
    int   tests = 0;
    int   fails = 0;
    int   sat_cyc;

    pipeline_ctrl_if pif();
    pipeline_ctrl_if sif();

    pipeline_ctrl #(.VEC_CYCLES(VC)) u_dut (.clk(clk), .rst(rst),  .bus(pif.slave));
    pipeline_ctrl #(.VEC_CYCLES(16)) u_sat (.clk(clk), .rst(srst), .bus(sif.slave));

    always #5 clk = ~clk;

    // Cycles elapsed since the saturation instance left reset.
    always @(posedge clk) begin
        if (srst) sat_cyc <= 0;
        else      sat_cyc <= sat_cyc + 1;
    end

    // Model state: in the flush-follow-up cycle, busy cycles remaining
    // (including the release cycle), in the cycle after a load stall.
    bit m_flush;
    bit m_ls;
    int m_busy;
    int m_stalls;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hit();
        logic [3:0] rs [3];
        bit hit = 0;
        rs[0] = pif.id_rs1; rs[1] = pif.id_rs2; rs[2] = pif.id_rs3;
        for (int i = 0; i < 3; i++) begin
            if (pif.id_src_use[i] && pif.ex_rd == rs[i] &&
                (pif.id_src_vec[i] ? pif.ex_regvwrite : pif.ex_regswrite))
                hit = 1;
        end
        return pif.ex_memtoreg && hit;
    endfunction

    task automatic step();
        bit hit;
        logic e_pc, e_ifd, e_idx, e_exm, e_iff, e_idf;
        logic [1:0] e_st;
        bit n_flush, n_ls;
        int n_busy, se;
        #1;
        hit = model_hit();
        {e_pc, e_ifd, e_idx, e_exm, e_iff, e_idf} = 6'b111100;
        e_st = 2'd0; n_flush = 0; n_ls = 0; n_busy = m_busy;
        if (rst) begin
            {e_pc, e_ifd, e_idx, e_exm, e_iff, e_idf} = 6'b000011;
            n_busy = 0;
        end else if (m_flush) begin
            e_st = 2'd3; e_iff = 1;
        end else if (m_busy > 0) begin
            e_st = 2'd2; n_busy = m_busy - 1;
            if (m_busy > 1) begin
                {e_pc, e_ifd, e_idx, e_exm} = 4'b0000;
            end else if (hit) begin
                e_pc = 0; e_ifd = 0; e_idf = 1; n_ls = 1;
            end
        end else begin
            e_st = m_ls ? 2'd1 : 2'd0;
            if (pif.branch_taken) begin
                e_iff = 1; e_idf = 1; n_flush = 1;
            end else if (pif.ex_vectorop && VC > 1) begin
                {e_pc, e_ifd, e_idx, e_exm} = 4'b0000;
                n_busy = VC - 1;
            end else if (hit && !m_ls) begin
                e_pc = 0; e_ifd = 0; e_idf = 1; n_ls = 1;
            end
        end
        chk("pc_en",        32'(pif.pc_en),        32'(e_pc));
        chk("if_id_en",     32'(pif.if_id_en),     32'(e_ifd));
        chk("id_ex_en",     32'(pif.id_ex_en),     32'(e_idx));
        chk("ex_mem_en",    32'(pif.ex_mem_en),    32'(e_exm));
        chk("if_id_flush",  32'(pif.if_id_flush),  32'(e_iff));
        chk("id_ex_flush",  32'(pif.id_ex_flush),  32'(e_idf));
        chk("state",        32'(pif.state),        32'(e_st));
        chk("stall_cycles", 32'(pif.stall_cycles), 32'(m_stalls));
        @(posedge clk);
        if (rst) m_stalls = 0;
        else if (!e_pc && m_stalls < 65535) m_stalls++;
        m_flush = n_flush; m_ls = n_ls; m_busy = n_busy;
        #1;
        // Held vector op at 16 cycles: 15 of every 16 cycles freeze the PC.
        if (!srst) begin
            se = sat_cyc - sat_cyc / 16;
            if (se > 65535) se = 65535;
            chk("sat_stalls", 32'(sif.stall_cycles), 32'(se));
        end
    endtask

    task automatic idle();
        pif.id_rs1 = 4'd0; pif.id_rs2 = 4'd0; pif.id_rs3 = 4'd0;
        pif.id_src_use = 3'b000; pif.id_src_vec = 3'b000; pif.ex_rd = 4'd0;
        pif.ex_memtoreg = 0; pif.ex_regswrite = 0; pif.ex_regvwrite = 0;
        pif.ex_vectorop = 0; pif.branch_taken = 0;
    endtask

    task automatic load_use(input logic [2:0] vec);
        idle();
        pif.ex_memtoreg = 1; pif.ex_regswrite = 1; pif.ex_rd = 4'd5;
        pif.id_rs2 = 4'd5; pif.id_src_use = 3'b010; pif.id_src_vec = vec;
    endtask

    task automatic rand_inputs();
        pif.id_rs1       = 4'($urandom_range(0, 3));
        pif.id_rs2       = 4'($urandom_range(0, 3));
        pif.id_rs3       = 4'($urandom_range(0, 3));
        pif.id_src_use   = 3'($urandom_range(0, 7));
        pif.id_src_vec   = 3'($urandom_range(0, 7));
        pif.ex_rd        = 4'($urandom_range(0, 3));
        pif.ex_memtoreg  = 1'($urandom_range(0, 1));
        pif.ex_regswrite = 1'($urandom_range(0, 1));
        pif.ex_regvwrite = 1'($urandom_range(0, 1));
        pif.ex_vectorop  = ($urandom_range(0, 9) == 0);
        pif.branch_taken = ($urandom_range(0, 7) == 0);
        rst              = ($urandom_range(0, 63) == 0);
    endtask

    initial begin
        m_flush = 0; m_ls = 0; m_busy = 0; m_stalls = 0;
        idle();
        sif.id_rs1 = 4'd0; sif.id_rs2 = 4'd0; sif.id_rs3 = 4'd0;
        sif.id_src_use = 3'b000; sif.id_src_vec = 3'b000; sif.ex_rd = 4'd0;
        sif.ex_memtoreg = 0; sif.ex_regswrite = 0; sif.ex_regvwrite = 0;
        sif.branch_taken = 0; sif.ex_vectorop = 1;
        rst = 1; srst = 1;
        @(posedge clk); #1;
        step(); step();
        rst = 0; srst = 0;

        // Load-use on scalar rs2: one stall, then LOAD_STALL with enables up.
        load_use(3'b000); step(); step();
        idle(); step();
        chk("ld_stalls", 32'(pif.stall_cycles), 32'd1);

        // Same indices but rs2 reads the vector file: no hazard.
        load_use(3'b010); step(); step();
        idle(); step();
        chk("ld_vec_mismatch", 32'(pif.stall_cycles), 32'd1);

        // Vector op: five frozen cycles then release and RUN.
        pif.ex_vectorop = 1; step();
        idle();
        for (int i = 0; i < 6; i++) step();
        chk("vec_stalls", 32'(pif.stall_cycles), 32'd6);

        // Branch beats a simultaneous load hit; FLUSH ignores inputs.
        load_use(3'b000); pif.branch_taken = 1; step();
        pif.branch_taken = 0; step();
        idle(); step();
        chk("br_stalls", 32'(pif.stall_cycles), 32'd6);

        // Reset in the middle of a vector op.
        pif.ex_vectorop = 1; step();
        idle(); step();
        rst = 1; step();
        chk("rst_mid_stalls", 32'(pif.stall_cycles), 32'd0);
        chk("rst_mid_state",  32'(pif.state),        32'd0);
        rst = 0; step(); step();

        // Random traffic with small register ranges to provoke hits.
        for (int i = 0; i < 1500; i++) begin
            rand_inputs();
            step();
        end
        rst = 0; idle();

        // Let the saturation instance run well past 0xFFFF stalled cycles.
        while (sat_cyc < 70000) step();
        chk("sat_final", 32'(sif.stall_cycles), 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
